parking_gate_controller: RTL and testbench

- Lane-side front end for the car park occupancy counter.
- Debounces the loop sensors of one entry lane and one exit lane, and runs one gate state machine per lane.
- Produces the single-cycle car_arrival / car_departure pulses that the occupancy counter consumes.
- Uses that counter's full_signal to refuse entry when the car park is full.

---
 rtl/parking_gate_controller.sv | 216 +++++++++++++++++++++
 tb/tb_parking_gate_controller.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/parking_gate_controller.sv
// Lane-side front end for the car park occupancy counter.
// Conditions the four loop sensors and runs one gate FSM per lane,
// producing single-cycle arrival/departure/denied/underflow pulses.
//
// Handshake: there is no valid/ready flow here. Every pulse output is a
// registered strobe that is high for exactly one clock per event, and the
// occupancy counter samples it on the next rising edge.

// Synchronizer plus debounce counter for one asynchronous loop sensor.
module parking_gate_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic raw_i,
    output logic level_o
);
    logic       sync1_q;
    logic       sync2_q;
    logic       level_q;
    logic [7:0] count_q;

    // Two-flop synchronizer, then count consecutive samples that disagree with the debounced level.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            count_q <= 8'd0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            if (sync2_q == level_q) begin
                count_q <= 8'd0;
            end else if (count_q == 8'(DEBOUNCE_CYCLES - 1)) begin
                // This sample is the DEBOUNCE_CYCLES-th disagreeing one.
                level_q <= ~level_q;
                count_q <= 8'd0;
            end else begin
                count_q <= count_q + 8'd1;
            end
        end
    end

    assign level_o = level_q;
endmodule

module parking_gate_controller #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned GATE_TIMEOUT    = 32
) (
    input  logic clock,
    input  logic reset,
    input  logic entry_presence_raw,
    input  logic entry_pass_raw,
    input  logic exit_presence_raw,
    input  logic exit_pass_raw,
    input  logic full_signal,
    input  logic empty_signal,
    output logic entry_gate_open,
    output logic exit_gate_open,
    output logic car_arrival,
    output logic car_departure,
    output logic entry_denied,
    output logic exit_underflow
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OPEN = 2'd1,
        ST_PASS = 2'd2
    } gate_state_e;

    logic en_pres_lvl, en_pass_lvl, ex_pres_lvl, ex_pass_lvl;
    logic en_pres_prev_q, en_pass_prev_q, ex_pres_prev_q, ex_pass_prev_q;
    logic en_pres_rise, en_pass_rise, en_pass_fall;
    logic ex_pres_rise, ex_pass_rise, ex_pass_fall;

    gate_state_e entry_state_q, entry_state_d;
    gate_state_e exit_state_q, exit_state_d;
    logic [15:0] entry_timer_q, entry_timer_d;
    logic [15:0] exit_timer_q, exit_timer_d;
    logic        arrival_q, arrival_d;
    logic        denied_q, denied_d;
    logic        departure_q, departure_d;
    logic        underflow_q, underflow_d;

    parking_gate_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_en_pres (
        .clock(clock), .reset(reset), .raw_i(entry_presence_raw), .level_o(en_pres_lvl));
    parking_gate_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_en_pass (
        .clock(clock), .reset(reset), .raw_i(entry_pass_raw), .level_o(en_pass_lvl));
    parking_gate_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ex_pres (
        .clock(clock), .reset(reset), .raw_i(exit_presence_raw), .level_o(ex_pres_lvl));
    parking_gate_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ex_pass (
        .clock(clock), .reset(reset), .raw_i(exit_pass_raw), .level_o(ex_pass_lvl));

    // Previous debounced levels, so edges are a compare of two registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            en_pres_prev_q <= 1'b0;
            en_pass_prev_q <= 1'b0;
            ex_pres_prev_q <= 1'b0;
            ex_pass_prev_q <= 1'b0;
        end else begin
            en_pres_prev_q <= en_pres_lvl;
            en_pass_prev_q <= en_pass_lvl;
            ex_pres_prev_q <= ex_pres_lvl;
            ex_pass_prev_q <= ex_pass_lvl;
        end
    end

    assign en_pres_rise = en_pres_lvl & ~en_pres_prev_q;
    assign en_pass_rise = en_pass_lvl & ~en_pass_prev_q;
    assign en_pass_fall = ~en_pass_lvl & en_pass_prev_q;
    assign ex_pres_rise = ex_pres_lvl & ~ex_pres_prev_q;
    assign ex_pass_rise = ex_pass_lvl & ~ex_pass_prev_q;
    assign ex_pass_fall = ~ex_pass_lvl & ex_pass_prev_q;

    // FSM state, timers and pulse registers for both lanes.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            entry_state_q <= ST_IDLE;
            exit_state_q  <= ST_IDLE;
            entry_timer_q <= 16'd0;
            exit_timer_q  <= 16'd0;
            arrival_q     <= 1'b0;
            denied_q      <= 1'b0;
            departure_q   <= 1'b0;
            underflow_q   <= 1'b0;
        end else begin
            entry_state_q <= entry_state_d;
            exit_state_q  <= exit_state_d;
            entry_timer_q <= entry_timer_d;
            exit_timer_q  <= exit_timer_d;
            arrival_q     <= arrival_d;
            denied_q      <= denied_d;
            departure_q   <= departure_d;
            underflow_q   <= underflow_d;
        end
    end

    // Entry lane: refuse on full, open, wait for pass rise or timeout, close on pass fall.
    always_comb begin
        entry_state_d = entry_state_q;
        entry_timer_d = entry_timer_q;
        arrival_d     = 1'b0;
        denied_d      = 1'b0;
        case (entry_state_q)
            ST_IDLE: begin
                if (en_pres_rise) begin
                    if (full_signal) begin
                        denied_d = 1'b1;
                    end else begin
                        entry_state_d = ST_OPEN;
                        entry_timer_d = 16'd0;
                    end
                end
            end
            ST_OPEN: begin
                entry_timer_d = entry_timer_q + 16'd1;
                // A pass rise takes priority over a timeout on the same cycle.
                if (en_pass_rise) begin
                    arrival_d     = 1'b1;
                    entry_state_d = ST_PASS;
                end else if (entry_timer_q == 16'(GATE_TIMEOUT - 1)) begin
                    entry_state_d = ST_IDLE;
                end
            end
            ST_PASS: begin
                if (en_pass_fall) begin
                    entry_state_d = ST_IDLE;
                end
            end
            default: entry_state_d = ST_IDLE;
        endcase
    end

    // Exit lane: never refused; flags underflow alongside a departure while empty.
    always_comb begin
        exit_state_d = exit_state_q;
        exit_timer_d = exit_timer_q;
        departure_d  = 1'b0;
        underflow_d  = 1'b0;
        case (exit_state_q)
            ST_IDLE: begin
                if (ex_pres_rise) begin
                    exit_state_d = ST_OPEN;
                    exit_timer_d = 16'd0;
                end
            end
            ST_OPEN: begin
                exit_timer_d = exit_timer_q + 16'd1;
                if (ex_pass_rise) begin
                    departure_d  = 1'b1;
                    underflow_d  = empty_signal;
                    exit_state_d = ST_PASS;
                end else if (exit_timer_q == 16'(GATE_TIMEOUT - 1)) begin
                    exit_state_d = ST_IDLE;
                end
            end
            ST_PASS: begin
                if (ex_pass_fall) begin
                    exit_state_d = ST_IDLE;
                end
            end
            default: exit_state_d = ST_IDLE;
        endcase
    end

    // Gate drive comes straight from the registered state, so reset drops it at once.
    assign entry_gate_open = (entry_state_q != ST_IDLE);
    assign exit_gate_open  = (exit_state_q != ST_IDLE);
    assign car_arrival     = arrival_q;
    assign car_departure   = departure_q;
    assign entry_denied    = denied_q;
    assign exit_underflow  = underflow_q;
endmodule

// File: tb/tb_parking_gate_controller.sv
// Directed bench for parking_gate_controller (DEBOUNCE_CYCLES=4, GATE_TIMEOUT=16).
// With debounce 4, a raw change reaches the debounced level 6 edges later
// and the FSM reacts one edge after that, so events show up on edge 7.
module tb_parking_gate_controller;
    logic clock;
    logic reset;
    logic entry_presence_raw, entry_pass_raw, exit_presence_raw, exit_pass_raw;
    logic full_signal, empty_signal;
    logic entry_gate_open, exit_gate_open;
    logic car_arrival, car_departure, entry_denied, exit_underflow;

    int vectors;
    int miscompares;
    int arrival_seen;
    int departure_seen;
    int denied_seen;

    parking_gate_controller #(.DEBOUNCE_CYCLES(4), .GATE_TIMEOUT(16)) dut (
        .clock(clock),
        .reset(reset),
        .entry_presence_raw(entry_presence_raw),
        .entry_pass_raw(entry_pass_raw),
        .exit_presence_raw(exit_presence_raw),
        .exit_pass_raw(exit_pass_raw),
        .full_signal(full_signal),
        .empty_signal(empty_signal),
        .entry_gate_open(entry_gate_open),
        .exit_gate_open(exit_gate_open),
        .car_arrival(car_arrival),
        .car_departure(car_departure),
        .entry_denied(entry_denied),
        .exit_underflow(exit_underflow)
    );

    // Clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Pulse counters sampled on the falling edge (one count per high cycle)
    always @(negedge clock) begin
        if (car_arrival)   arrival_seen++;
        if (car_departure) departure_seen++;
        if (entry_denied)  denied_seen++;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all_low(input string tag);
        check(tag, {26'd0, entry_gate_open, exit_gate_open, car_arrival,
                    car_departure, entry_denied, exit_underflow}, 32'd0);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        arrival_seen = 0;
        departure_seen = 0;
        denied_seen = 0;
        reset = 1'b0;
        entry_presence_raw = 1'b0;
        entry_pass_raw = 1'b0;
        exit_presence_raw = 1'b0;
        exit_pass_raw = 1'b0;
        full_signal = 1'b0;
        empty_signal = 1'b0;

        // Reset state
        step(3);
        check_all_low("reset_outputs");
        reset = 1'b1;
        step(3);
        check_all_low("idle_after_reset");

        // Normal entry
        entry_presence_raw = 1'b1;
        step(6);
        check("entry_gate_before", 32'(entry_gate_open), 32'd0);
        step(1);
        check("entry_gate_open", 32'(entry_gate_open), 32'd1);
        check("exit_gate_untouched", 32'(exit_gate_open), 32'd0);
        entry_pass_raw = 1'b1;
        step(6);
        check("arrival_before", 32'(car_arrival), 32'd0);
        step(1);
        check("arrival_pulse", 32'(car_arrival), 32'd1);
        step(1);
        check("arrival_one_cycle", 32'(car_arrival), 32'd0);
        check("gate_held_in_pass", 32'(entry_gate_open), 32'd1);
        entry_pass_raw = 1'b0;
        step(6);
        check("gate_before_close", 32'(entry_gate_open), 32'd1);
        step(1);
        check("gate_closed_after_pass", 32'(entry_gate_open), 32'd0);
        entry_presence_raw = 1'b0;
        step(8);

        // Entry while full
        full_signal = 1'b1;
        entry_presence_raw = 1'b1;
        step(6);
        check("denied_before", 32'(entry_denied), 32'd0);
        step(1);
        check("denied_pulse", 32'(entry_denied), 32'd1);
        check("denied_gate_low", 32'(entry_gate_open), 32'd0);
        step(1);
        check("denied_one_cycle", 32'(entry_denied), 32'd0);
        full_signal = 1'b0;
        step(20);
        check("held_presence_no_open", 32'(entry_gate_open), 32'd0);
        check("denied_count", 32'(denied_seen), 32'd1);
        check("no_arrival_when_full", 32'(arrival_seen), 32'd1);

        // Re-trigger presence, then let the gate time out
        entry_presence_raw = 1'b0;
        step(8);
        entry_presence_raw = 1'b1;
        step(7);
        check("retrigger_open", 32'(entry_gate_open), 32'd1);
        step(15);
        check("open_before_timeout", 32'(entry_gate_open), 32'd1);
        step(1);
        check("closed_at_timeout", 32'(entry_gate_open), 32'd0);
        check("timeout_no_arrival", 32'(arrival_seen), 32'd1);

        // 3-cycle presence glitch is ignored
        entry_presence_raw = 1'b0;
        step(8);
        entry_presence_raw = 1'b1;
        step(3);
        entry_presence_raw = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step(1);
            check("glitch_no_gate", 32'(entry_gate_open), 32'd0);
        end
        check("glitch_no_denied", 32'(denied_seen), 32'd1);

        // Reset asserted mid-OPEN
        entry_presence_raw = 1'b1;
        step(7);
        check("open_before_reset", 32'(entry_gate_open), 32'd1);
        reset = 1'b0;
        #1;
        check_all_low("async_reset_mid_open");
        reset = 1'b1;
        step(6);
        check("post_reset_gate_before", 32'(entry_gate_open), 32'd0);
        step(1);
        check("post_reset_gate_open", 32'(entry_gate_open), 32'd1);

        // Let it time out, then simultaneous entry and exit
        entry_presence_raw = 1'b0;
        step(20);
        check("idle_before_simul", 32'(entry_gate_open), 32'd0);
        entry_presence_raw = 1'b1;
        exit_presence_raw = 1'b1;
        step(7);
        check("simul_entry_open", 32'(entry_gate_open), 32'd1);
        check("simul_exit_open", 32'(exit_gate_open), 32'd1);
        entry_pass_raw = 1'b1;
        exit_pass_raw = 1'b1;
        step(7);
        check("simul_arrival", 32'(car_arrival), 32'd1);
        check("simul_departure", 32'(car_departure), 32'd1);
        check("simul_no_underflow", 32'(exit_underflow), 32'd0);
        step(1);
        check("simul_pulses_end", 32'({car_arrival, car_departure}), 32'd0);
        entry_pass_raw = 1'b0;
        exit_pass_raw = 1'b0;
        step(7);
        check("simul_gates_closed", 32'({entry_gate_open, exit_gate_open}), 32'd0);
        entry_presence_raw = 1'b0;
        exit_presence_raw = 1'b0;
        step(8);

        // Exit while empty
        empty_signal = 1'b1;
        exit_presence_raw = 1'b1;
        step(7);
        check("underflow_exit_open", 32'(exit_gate_open), 32'd1);
        exit_pass_raw = 1'b1;
        step(6);
        check("underflow_before", 32'(exit_underflow), 32'd0);
        step(1);
        check("underflow_departure", 32'(car_departure), 32'd1);
        check("underflow_pulse", 32'(exit_underflow), 32'd1);
        step(1);
        check("underflow_one_cycle", 32'(exit_underflow), 32'd0);
        exit_pass_raw = 1'b0;
        exit_presence_raw = 1'b0;
        step(8);
        check("total_arrivals", 32'(arrival_seen), 32'd2);
        check("total_departures", 32'(departure_seen), 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
